dmem_responder: RTL
===================

Name: dmem_responder

Overview:
Single-clock data-memory responder that answers the CPU's dmem initiator port (address/op/write-enable/data). It provides a byte-enabled word RAM with RISC-V load/store alignment and sign extension. It also provides a small MMIO window with a keyboard receive FIFO and a terminal transmit FIFO. It sits between the pipelined core and the board peripherals in the system top level.

Parameters:
RAM_AW, 15, RAM word-address bits (RAM = 2^RAM_AW words)
KEY_DEPTH, 8, keyboard FIFO entries (power of 2, >=2)
TTY_DEPTH, 8, terminal FIFO entries (power of 2, >=2)

Ports:
clock  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-low reset
dmemaddr  in  32  byte address
dmemop  in  3  RISC-V funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
dmemre  in  1  read request this cycle
dmemwe  in  1  write request this cycle
dmemdatain  in  32  store data, right-aligned
dmemdataout  out  32  load result, registered
dmemerr  out  1  one-cycle pulse: misaligned or unmapped access
key_valid  in  1  keyboard byte strobe
key_data  in  8  keyboard scan code
tty_valid  out  1  terminal byte available
tty_data  out  8  terminal byte
tty_ready  in  1  terminal consumer accepts byte

Behaviour:
- Reset (reset==0 at edge): dmemdataout=0, dmemerr=0, tty_valid=0, tty_data=0, both FIFOs empty, sticky overflow bits=0. RAM contents are not cleared. Reset overrides every concurrent request.
- Decode: addr[31:28]==4'h0 -> RAM (word index addr[RAM_AW+1:2]); addr[31:4]==28'hF000000 -> MMIO; anything else unmapped: reads return 0, writes dropped, dmemerr pulses.
- dmemre and dmemwe both high: write wins, read ignored, dmemdataout holds.
- Load latency 1: request at edge N -> dmemdataout valid after edge N+1 and held until the next read.
- Byte lane = addr[1:0]; half lane = addr[1]. B/H sign-extend, BU/HU zero-extend, W passes through. Undefined op codes behave as W.
- Misaligned accesses (H with addr[0]=1; W with addr[1:0]!=0): the access is performed with the low bits forced to alignment, and dmemerr pulses for one cycle.
- Stores: SB writes one byte lane, SH writes two lanes, SW writes four lanes, using per-byte enables. No read-modify-write.
- A read of a word in the cycle after a store to it returns the new data.
- MMIO registers (word offsets; only W accesses are meaningful, other sizes are treated as W):
  0x0 KEY_STATUS (RO): bit0 = key FIFO non-empty, bits[4:1] = count (saturates at 15), bit5 = key overflow (sticky).
  0x4 KEY_DATA (RO): zero-extended head byte. The read pops the FIFO. Reading when empty returns 0 with no pop.
  0x8 TTY_STATUS: bit0 = tty FIFO full, bit1 = tty overflow (sticky). Writing 1 to bit1 clears it.
  0xC TTY_DATA (WO): pushes dmemdatain[7:0]. A push when full is dropped and sets tty overflow.
  Reads of write-only or unused offsets return 0.
- Key FIFO:
  - key_valid pushes key_data. A push when full is dropped and sets key overflow; clear only by reset.
  - Push and pop in the same cycle when full: both occur and count is unchanged.
  - Push and pop in the same cycle when empty: the read returns 0, the push is kept, and count becomes 1.
- Tty FIFO:
  - tty_valid = non-empty; tty_data = head byte.
  - The head is popped at an edge where tty_valid && tty_ready.
  - Simultaneous CPU push and consumer pop when full: both occur.
  - tty_data must not change while tty_valid && !tty_ready.
- Pointers wrap modulo depth. Full/empty are determined by an explicit count or by an extra pointer bit.

Test Plan:
- SW 0x12345678 to 0x100, then LW 0x100 -> 0x12345678 one cycle after the request. LB 0x103 -> 0x00000012. LH 0x102 -> 0x00001234.
- SB 0xFF to 0x101, then LB 0x101 -> 0xFFFFFFFF, LBU 0x101 -> 0x000000FF, LW 0x100 -> 0x1234FF78.
- LW 0x102 -> dmemerr pulses for one cycle and the data returned is word 0x100. LW 0x20000000 -> dmemdataout=0 and dmemerr=1.
- Push keys 0x1C, 0x32: KEY_STATUS=0x5. Two KEY_DATA reads -> 0x1C then 0x32. A third read -> 0 with KEY_STATUS=0. Nine pushes with no pops -> KEY_STATUS bit5=1 and count=8.
- Write 'A','B' to TTY_DATA with tty_ready=0: tty_valid=1 and tty_data holds 0x41. Raise tty_ready for 2 cycles -> 0x41 then 0x42 delivered, then tty_valid=0.
- Assert reset low mid-stream with both FIFOs non-empty -> the next cycle shows all FIFOs empty, tty_valid=0, dmemdataout=0, and RAM word 0x100 is unchanged.

Source files
------------

// File: rtl/dmem_responder.sv
// dmem_responder: byte-enabled word RAM plus keyboard/terminal MMIO FIFOs behind the CPU dmem port
module dmem_responder #(
  parameter int RAM_AW    = 15,
  parameter int KEY_DEPTH = 8,
  parameter int TTY_DEPTH = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] dmemaddr,
  input  logic [2:0]  dmemop,
  input  logic        dmemre,
  input  logic        dmemwe,
  input  logic [31:0] dmemdatain,
  output logic [31:0] dmemdataout,
  output logic        dmemerr,
  input  logic        key_valid,
  input  logic [7:0]  key_data,
  output logic        tty_valid,
  output logic [7:0]  tty_data,
  input  logic        tty_ready
);
  localparam int KW = $clog2(KEY_DEPTH);
  localparam int TW = $clog2(TTY_DEPTH);

  logic [31:0] ram [2**RAM_AW];
  logic [7:0]  key_mem [KEY_DEPTH];
  logic [7:0]  tty_mem [TTY_DEPTH];

  logic [31:0]   dout_q, dout_d;
  logic          err_q, err_d;
  logic [KW:0]   kcnt_q, kcnt_d;
  logic [KW-1:0] kwp_q, kwp_d, krp_q, krp_d;
  logic          kovf_q, kovf_d;
  logic [TW:0]   tcnt_q, tcnt_d;
  logic [TW-1:0] twp_q, twp_d, trp_q, trp_d;
  logic          tovf_q, tovf_d;

  logic              rd, is_ram, is_mmio, is_b, is_h, mis;
  logic              k_full, k_pop, k_push, t_full, t_pop, t_push, t_acc;
  logic [1:0]        off;
  logic [RAM_AW-1:0] idx;
  logic [31:0]       word, ram_rd, mmio_rd, wdata;
  logic [7:0]        bsel;
  logic [15:0]       hsel;
  logic [3:0]        be, ksat;
  logic              unused_addr;

  always_comb begin
    rd      = dmemre & ~dmemwe;
    is_ram  = dmemaddr[31:28] == 4'h0;
    is_mmio = dmemaddr[31:4] == 28'hF000000;
    // MMIO ignores the op size and always behaves as a word access
    is_b    = is_ram & (dmemop[1:0] == 2'b00);
    is_h    = is_ram & (dmemop[1:0] == 2'b01);
    mis     = is_h ? dmemaddr[0] : ~is_b & (dmemaddr[1:0] != 2'b00);
    err_d   = (dmemre | dmemwe) & (mis | ~(is_ram | is_mmio));
    off     = dmemaddr[3:2];
    idx     = dmemaddr[RAM_AW+1:2];
    word    = ram[idx];
    bsel    = word[{dmemaddr[1:0], 3'b000} +: 8];
    hsel    = word[{dmemaddr[1], 4'b0000} +: 16];
    ram_rd  = is_b ? {{24{bsel[7] & ~dmemop[2]}}, bsel} :
              is_h ? {{16{hsel[15] & ~dmemop[2]}}, hsel} : word;
    be      = is_b ? 4'b0001 << dmemaddr[1:0] : is_h ? (dmemaddr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    wdata   = is_b ? {4{dmemdatain[7:0]}} : is_h ? {2{dmemdatain[15:0]}} : dmemdatain;
    k_full  = kcnt_q == (KW+1)'(KEY_DEPTH);
    ksat    = 32'(kcnt_q) > 32'd15 ? 4'hF : 4'(kcnt_q);
    k_pop   = rd & is_mmio & (off == 2'd1) & (kcnt_q != '0);
    k_push  = key_valid & (~k_full | k_pop);
    t_full  = tcnt_q == (TW+1)'(TTY_DEPTH);
    t_pop   = (tcnt_q != '0) & tty_ready;
    t_push  = dmemwe & is_mmio & (off == 2'd3);
    t_acc   = t_push & (~t_full | t_pop);
    mmio_rd = off == 2'd0 ? {26'd0, kovf_q, ksat, kcnt_q != '0} :
              off == 2'd1 ? (kcnt_q != '0 ? {24'd0, key_mem[krp_q]} : 32'd0) :
              off == 2'd2 ? {30'd0, tovf_q, t_full} : 32'd0;
    dout_d  = rd ? (is_ram ? ram_rd : is_mmio ? mmio_rd : 32'd0) : dout_q;
    kcnt_d  = kcnt_q + (KW+1)'(k_push) - (KW+1)'(k_pop);
    kwp_d   = kwp_q + KW'(k_push);
    krp_d   = krp_q + KW'(k_pop);
    kovf_d  = kovf_q | (key_valid & ~k_push);
    tcnt_d  = tcnt_q + (TW+1)'(t_acc) - (TW+1)'(t_pop);
    twp_d   = twp_q + TW'(t_acc);
    trp_d   = trp_q + TW'(t_pop);
    tovf_d  = (tovf_q & ~(dmemwe & is_mmio & (off == 2'd2) & dmemdatain[1])) | (t_push & ~t_acc);
    unused_addr = ^dmemaddr;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      dout_q <= '0;
      err_q  <= 1'b0;
      kcnt_q <= '0;
      kwp_q  <= '0;
      krp_q  <= '0;
      kovf_q <= 1'b0;
      tcnt_q <= '0;
      twp_q  <= '0;
      trp_q  <= '0;
      tovf_q <= 1'b0;
    end else begin
      dout_q <= dout_d;
      err_q  <= err_d;
      kcnt_q <= kcnt_d;
      kwp_q  <= kwp_d;
      krp_q  <= krp_d;
      kovf_q <= kovf_d;
      tcnt_q <= tcnt_d;
      twp_q  <= twp_d;
      trp_q  <= trp_d;
      tovf_q <= tovf_d;
    end
  end

  // storage is never cleared; reset only blocks writes
  always_ff @(posedge clock) begin
    if (reset) begin
      if (dmemwe & is_ram)
        for (int i = 0; i < 4; i++)
          if (be[i]) ram[idx][8*i +: 8] <= wdata[8*i +: 8];
      if (k_push) key_mem[kwp_q] <= key_data;
      if (t_acc) tty_mem[twp_q] <= dmemdatain[7:0];
    end
  end

  assign dmemdataout = dout_q;
  assign dmemerr     = err_q;
  assign tty_valid   = tcnt_q != '0;
  assign tty_data    = tty_valid ? tty_mem[trp_q] : 8'h00;
endmodule
